// File: rtl/gate_bist_pkg.sv
// Shared types and defaults for the gate signature analyzer.
// Sizes and the MISR feedback polynomial live here.
package gate_bist_pkg;

   localparam int WIDTH_DEF = 10;
   localparam int CNT_W_DEF = 16;

   // x^10 + x^7 + 1
   localparam logic [9:0] TAPS_DEF = 10'h240;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register.
// Seed load takes priority over a compaction step.
module misr_reg #(
   parameter int                 WIDTH = 10,
   parameter logic [WIDTH-1:0]   TAPS  = 10'h240
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] seed_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] sig_o
);

   logic [WIDTH-1:0] sig_q;
   logic [WIDTH-1:0] sig_d;
   logic             fb;

   assign fb = ^(sig_q & TAPS);

   always_comb begin
      sig_d = sig_q;
      if (load_i) begin
         sig_d = seed_i;
      end else if (en_i) begin
         sig_d = {sig_q[WIDTH-2:0], fb} ^ data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/gate_signature_analyzer.sv
// Compacts gate-model responses into a MISR signature over a
// programmed pattern count and flags a match with the golden value.
module gate_signature_analyzer
   import gate_bist_pkg::*;
#(
   parameter int               WIDTH = WIDTH_DEF,
   parameter int               CNT_W = CNT_W_DEF,
   parameter logic [WIDTH-1:0] TAPS  = TAPS_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] n_patterns,
   input  logic [WIDTH-1:0] seed,
   input  logic [WIDTH-1:0] expected,
   input  logic             resp_valid,
   input  logic [WIDTH-1:0] resp_data,
   output logic             resp_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic             load;
   logic             xfer;

   assign load = start && (state_q != ST_RUN);
   assign xfer = resp_valid && (state_q == ST_RUN);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               exp_d   = expected;
               cnt_d   = n_patterns;
               state_d = (n_patterns != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (xfer) begin
               cnt_d = cnt_q - CNT_W'(1);
               // last pattern: counter exits before it can wrap
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         exp_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
      end
   end

   misr_reg #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_misr (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load),
      .seed_i (seed),
      .en_i   (xfer),
      .data_i (resp_data),
      .sig_o  (signature)
   );

   assign resp_ready = (state_q == ST_RUN);
   assign busy       = (state_q == ST_RUN);
   assign done       = (state_q == ST_DONE);
   assign pass       = done && (signature == exp_q);

endmodule

// File: tb/tb_gate_signature_analyzer.sv
// Directed bench for gate_signature_analyzer; final signatures are
// queued at start and checked by a monitor when done rises.
module tb_gate_signature_analyzer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] n_patterns;
   logic [9:0]  seed;
   logic [9:0]  expected;
   logic        resp_valid;
   logic [9:0]  resp_data;
   logic        resp_ready;
   logic        busy;
   logic        done;
   logic        pass;
   logic [9:0]  signature;

   typedef struct {
      logic [9:0] sig;
      logic       pass;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   done_prev = 1'b0;

   always #5 clk = ~clk;

   gate_signature_analyzer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .n_patterns (n_patterns),
      .seed       (seed),
      .expected   (expected),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_ready (resp_ready),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .signature  (signature)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   // monitor: one expected result per rising edge of done
   always @(negedge clk) begin
      if (done && !done_prev) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_empty: got sig %0h want none", signature);
         end else begin
            e = sb.pop_front();
            chk("sb_sig", {22'd0, signature}, {22'd0, e.sig});
            chk("sb_pass", {31'd0, pass}, {31'd0, e.pass});
         end
      end
      done_prev = done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(int n, logic [9:0] sd, logic [9:0] ex);
      start      = 1'b1;
      n_patterns = 16'(n);
      seed       = sd;
      expected   = ex;
      tick();
      start = 1'b0;
   endtask

   task automatic xfer(logic [9:0] d);
      resp_valid = 1'b1;
      resp_data  = d;
      tick();
      resp_valid = 1'b0;
   endtask

   task automatic wait_done(string nm);
      for (int i = 0; i < 50 && !done; i++) tick();
      chk({nm, "_timeout"}, {31'd0, done}, 32'd1);
   endtask

   task automatic chk_zero(string nm);
      chk({nm, "_ready"}, {31'd0, resp_ready}, 32'd0);
      chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
      chk({nm, "_done"}, {31'd0, done}, 32'd0);
      chk({nm, "_pass"}, {31'd0, pass}, 32'd0);
      chk({nm, "_sig"}, {22'd0, signature}, 32'd0);
   endtask

   logic       vpat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [9:0] dpat [3] = '{10'h3A5, 10'h0F0, 10'h111};

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int k;
      rst_n      = 1'b0;
      start      = 1'b0;
      n_patterns = '0;
      seed       = '0;
      expected   = '0;
      resp_valid = 1'b0;
      resp_data  = '0;
      tick();
      tick();
      chk_zero("reset");
      rst_n = 1'b1;
      tick();

      // single pattern, seed 0
      sb.push_back('{10'h3A5, 1'b1});
      do_start(1, 10'h000, 10'h3A5);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      chk("t1_ready", {31'd0, resp_ready}, 32'd1);
      chk("t1_done_early", {31'd0, done}, 32'd0);
      xfer(10'h3A5);
      chk("t1_done_lat", {31'd0, done}, 32'd1);
      chk("t1_busy_end", {31'd0, busy}, 32'd0);
      wait_done("t1");

      // two patterns, mismatch
      sb.push_back('{10'h003, 1'b0});
      do_start(2, 10'h000, 10'h001);
      xfer(10'h001);
      chk("t2_sig1", {22'd0, signature}, 32'h001);
      chk("t2_done_mid", {31'd0, done}, 32'd0);
      xfer(10'h001);
      chk("t2_done_lat", {31'd0, done}, 32'd1);
      wait_done("t2");

      // feedback taps
      sb.push_back('{10'h001, 1'b1});
      do_start(1, 10'h200, 10'h001);
      xfer(10'h000);
      wait_done("t3a");
      sb.push_back('{10'h080, 1'b1});
      do_start(1, 10'h240, 10'h080);
      xfer(10'h000);
      wait_done("t3b");

      // stalls plus an ignored start
      sb.push_back('{10'h266, 1'b1});
      do_start(3, 10'h000, 10'h266);
      k = 0;
      for (int i = 0; i < 6; i++) begin
         resp_valid = vpat[i];
         resp_data  = vpat[i] ? dpat[k] : 10'h3FF;
         if (vpat[i]) k++;
         if (i == 2) begin
            start      = 1'b1;
            n_patterns = 16'd1;
            seed       = 10'h3FF;
            expected   = 10'h3FF;
         end
         tick();
         start      = 1'b0;
         resp_valid = 1'b0;
         chk($sformatf("t4_done_c%0d", i + 2),
             {31'd0, done}, (i == 5) ? 32'd1 : 32'd0);
      end
      chk("t4_sig", {22'd0, signature}, 32'h266);

      // zero patterns from IDLE
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t5_idle_done", {31'd0, done}, 32'd0);
      sb.push_back('{10'h155, 1'b1});
      do_start(0, 10'h155, 10'h155);
      chk("t5_done", {31'd0, done}, 32'd1);
      chk("t5_pass", {31'd0, pass}, 32'd1);
      chk("t5_ready", {31'd0, resp_ready}, 32'd0);
      chk("t5_sig", {22'd0, signature}, 32'h155);
      tick();
      chk("t5_ready2", {31'd0, resp_ready}, 32'd0);

      // reset mid-run discards the run
      do_start(5, 10'h000, 10'h000);
      xfer(10'h001);
      xfer(10'h002);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_zero("t6_rst");
      sb.push_back('{10'h154, 1'b1});
      do_start(1, 10'h0AA, 10'h154);
      xfer(10'h000);
      wait_done("t6");

      tick();
      tick();
      chk("sb_drain", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
